// File: rtl/grid_step_unit.sv
`default_nettype none
// ============================================================================
//  Module   : grid_step_unit
//  Purpose  : Computes the neighbouring grid location one step away from
//             currLoc in direction dir, flags edge wrap-around, and keeps a
//             load-enabled registered copy of the current location.
//  Ports    : clk       - clock, state updates on rising edge
//             rst       - synchronous active-low reset (clears locQ)
//             rgLd      - load enable for the X/Y location registers
//             dir[1:0]  - 00 Y-1, 01 X+1, 10 X-1, 11 Y+1
//             currLoc   - {X, Y} current location
//             nxtLoc    - {X, Y} after one step (combinational)
//             cntReach  - selected coordinate wraps past the grid edge
//             co        - carry-out of the step adder
//             locQ      - registered {X, Y}
//  Revision : 1.0 - initial release
// ============================================================================

// ---------------------------------------------------------------------------
//  gsu_adder : W-bit adder with carry-in and carry-out
// ---------------------------------------------------------------------------
module gsu_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] sum_o,
  output logic         co_o
);
  assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};
endmodule

// ---------------------------------------------------------------------------
//  gsu_mux2 : W-bit 2:1 mux, sl_i = 1 selects in1_i
// ---------------------------------------------------------------------------
module gsu_mux2 #(
  parameter int W = 4
) (
  input  logic [W-1:0] in0_i,
  input  logic [W-1:0] in1_i,
  input  logic         sl_i,
  output logic [W-1:0] y_o
);
  assign y_o = sl_i ? in1_i : in0_i;
endmodule

// ---------------------------------------------------------------------------
//  gsu_reg : W-bit load-enabled register, synchronous active-low reset
// ---------------------------------------------------------------------------
module gsu_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  assign data_d = ld_i ? d_i : data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;
endmodule

// ---------------------------------------------------------------------------
//  grid_step_unit : top level
// ---------------------------------------------------------------------------
module grid_step_unit #(
  parameter int COORD_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rgLd,
  input  logic [1:0]           dir,
  input  logic [2*COORD_W-1:0] currLoc,
  output logic [2*COORD_W-1:0] nxtLoc,
  output logic                 cntReach,
  output logic                 co,
  output logic [2*COORD_W-1:0] locQ
);
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               sl;
  logic [COORD_W-1:0] addTo;
  logic [COORD_W-1:0] operand;
  logic [COORD_W-1:0] res;
  logic [COORD_W-1:0] wrapChk;
  logic [COORD_W-1:0] xQ;
  logic [COORD_W-1:0] yQ;

  assign x = currLoc[2*COORD_W-1:COORD_W];
  assign y = currLoc[COORD_W-1:0];

  // Directions 01/10 move along X, 00/11 along Y.
  assign sl = dir[1] ^ dir[0];

  // dir[0] picks the sign: +1, or -1 as the all-ones two's complement.
  assign operand = dir[0] ? {{(COORD_W-1){1'b0}}, 1'b1} : {COORD_W{1'b1}};

  gsu_mux2 #(.W(COORD_W)) u_mux (
    .in0_i (y),
    .in1_i (x),
    .sl_i  (sl),
    .y_o   (addTo)
  );

  gsu_adder #(.W(COORD_W)) u_add (
    .a_i   (addTo),
    .b_i   (operand),
    .ci_i  (1'b0),
    .sum_o (res),
    .co_o  (co)
  );

  // Zero here means an increment from all-ones or a decrement from zero,
  // i.e. the step crosses the grid edge.
  assign wrapChk  = addTo + {{(COORD_W-1){1'b0}}, dir[0]};
  assign cntReach = (wrapChk == '0);

  assign nxtLoc = sl ? {res, y} : {x, res};

  gsu_reg #(.W(COORD_W)) u_reg_x (
    .clk  (clk),
    .rst  (rst),
    .ld_i (rgLd),
    .d_i  (x),
    .q_o  (xQ)
  );

  gsu_reg #(.W(COORD_W)) u_reg_y (
    .clk  (clk),
    .rst  (rst),
    .ld_i (rgLd),
    .d_i  (y),
    .q_o  (yQ)
  );

  assign locQ = {xQ, yQ};
endmodule
`default_nettype wire

// File: tb/tb_grid_step_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grid_step_unit
//  Purpose  : Directed self-checking bench for grid_step_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_grid_step_unit;
  logic       clk;
  logic       rst;
  logic       rgLd;
  logic [1:0] dir;
  logic [7:0] currLoc;
  logic [7:0] nxtLoc;
  logic       cntReach;
  logic       co;
  logic [7:0] locQ;

  int tests;
  int fails;

  grid_step_unit #(.COORD_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .rgLd     (rgLd),
    .dir      (dir),
    .currLoc  (currLoc),
    .nxtLoc   (nxtLoc),
    .cntReach (cntReach),
    .co       (co),
    .locQ     (locQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b0;
    rgLd    = 1'b0;
    dir     = 2'b00;
    currLoc = 8'h00;

    // Reset
    tick();
    check("reset_locQ", locQ, 8'h00);

    // Combinational step vectors
    rst = 1'b1;
    currLoc = 8'h35; dir = 2'b01; #1;
    check("35_d01_nxt", nxtLoc, 8'h45);
    check("35_d01_reach", {7'd0, cntReach}, 8'h00);
    check("35_d01_co", {7'd0, co}, 8'h00);

    dir = 2'b00; #1;
    check("35_d00_nxt", nxtLoc, 8'h34);
    check("35_d00_reach", {7'd0, cntReach}, 8'h00);
    check("35_d00_co", {7'd0, co}, 8'h01);

    dir = 2'b11; #1;
    check("35_d11_nxt", nxtLoc, 8'h36);
    check("35_d11_reach", {7'd0, cntReach}, 8'h00);

    dir = 2'b10; #1;
    check("35_d10_nxt", nxtLoc, 8'h25);
    check("35_d10_co", {7'd0, co}, 8'h01);

    // Wrap-around boundaries
    currLoc = 8'hF7; dir = 2'b01; #1;
    check("F7_d01_nxt", nxtLoc, 8'h07);
    check("F7_d01_reach", {7'd0, cntReach}, 8'h01);
    check("F7_d01_co", {7'd0, co}, 8'h01);

    currLoc = 8'h70; dir = 2'b00; #1;
    check("70_d00_nxt", nxtLoc, 8'h7F);
    check("70_d00_reach", {7'd0, cntReach}, 8'h01);
    check("70_d00_co", {7'd0, co}, 8'h00);

    currLoc = 8'h0A; dir = 2'b10; #1;
    check("0A_d10_nxt", nxtLoc, 8'hFA);
    check("0A_d10_reach", {7'd0, cntReach}, 8'h01);
    check("0A_d10_co", {7'd0, co}, 8'h00);

    currLoc = 8'hAF; dir = 2'b11; #1;
    check("AF_d11_nxt", nxtLoc, 8'hA0);
    check("AF_d11_reach", {7'd0, cntReach}, 8'h01);
    check("AF_d11_co", {7'd0, co}, 8'h01);

    // Non-wrapping near the edge: Y=E incremented, X=1 decremented
    currLoc = 8'h1E; dir = 2'b11; #1;
    check("1E_d11_nxt", nxtLoc, 8'h1F);
    check("1E_d11_reach", {7'd0, cntReach}, 8'h00);
    dir = 2'b10; #1;
    check("1E_d10_nxt", nxtLoc, 8'h0E);
    check("1E_d10_reach", {7'd0, cntReach}, 8'h00);

    // Register load / hold
    rst = 1'b1; rgLd = 1'b1; currLoc = 8'h5C;
    tick();
    check("load_5C", locQ, 8'h5C);
    rgLd = 1'b0; currLoc = 8'h12;
    tick();
    check("hold_5C", locQ, 8'h5C);

    // Mid-cycle reset must wait for the edge; comb path stays live
    rgLd = 1'b1; currLoc = 8'hF7; dir = 2'b01;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_locQ", locQ, 8'h5C);
    check("rst_comb_nxt", nxtLoc, 8'h07);
    check("rst_comb_reach", {7'd0, cntReach}, 8'h01);
    tick();
    check("rst_edge_locQ", locQ, 8'h00);

    // Load after release with a different pattern
    rst = 1'b1; rgLd = 1'b1; currLoc = 8'hA3;
    tick();
    check("load_A3", locQ, 8'hA3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/grid_step_unit.md
GRID_STEP_UNIT -- requirements
Module: grid_step_unit

Interface
REQ-001 Parameter COORD_W, default 4, width of each coordinate field; location bus is 2*COORD_W bits; all values below assume default.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-low, sampled on clk rising edge.
REQ-004 rgLd  input  1  load enable for location registers.
REQ-005 dir  input  2  move direction: 00 = Y-1, 01 = X+1, 10 = X-1, 11 = Y+1.
REQ-006 currLoc  input  8  current location; [7:4] = X, [3:0] = Y, unsigned.
REQ-007 nxtLoc  output  8  next location after one step in dir; same packing as currLoc.
REQ-008 cntReach  output  1  high when the selected coordinate would wrap past the grid edge.
REQ-009 co  output  1  carry-out of the 4-bit step adder.
REQ-010 locQ  output  8  registered copy of currLoc, {X register, Y register}.

Function
REQ-011 Block SHALL be built from three submodules: a 4-bit adder (a, b, carry-in, sum, carry-out), a 4-bit 2:1 mux (sl = 1 selects in1), and a 4-bit load-enabled register with synchronous active-low reset.
REQ-012 Axis select sl = dir[1] XOR dir[0]; sl = 1 selects X, sl = 0 selects Y.
REQ-013 Mux SHALL output addTo = X when sl = 1, else Y.
REQ-014 Step operand SHALL be +1 (4'h1) when dir[0] = 1, else -1 (4'hF); adder carry-in tied to 0.
REQ-015 Adder sum res = (addTo + operand) mod 16; co = bit 4 of the unsigned 5-bit sum.
REQ-016 nxtLoc SHALL be {res, Y} when sl = 1, else {X, res}; the unselected coordinate passes through unchanged.
REQ-017 nxtLoc, co, cntReach SHALL be purely combinational from currLoc and dir: zero-cycle latency, unaffected by clk, rst, rgLd.
REQ-018 cntReach SHALL equal ((addTo + dir[0]) mod 16 == 0): i.e. 1 when incrementing from 15 or decrementing from 0, else 0.
REQ-019 Wrap-around: increment of 15 SHALL yield 0 with cntReach = 1, co = 1; decrement of 0 SHALL yield 15 with cntReach = 1, co = 0.
REQ-020 Decrement of any nonzero value SHALL give co = 1; increment of any value below 15 SHALL give co = 0.
REQ-021 On rising clk with rst = 1 and rgLd = 1, X register SHALL capture currLoc[7:4] and Y register currLoc[3:0]; locQ updates the same edge.
REQ-022 With rst = 1 and rgLd = 0 registers SHALL hold value.
REQ-023 No handshake; no internal state besides the two 4-bit registers; no FSM.

Reset
REQ-024 On rising clk with rst = 0, both registers SHALL clear to 0 (locQ = 8'h00), overriding rgLd.
REQ-025 Reset SHALL NOT act asynchronously: asserting rst = 0 between edges leaves locQ unchanged until the next rising edge.
REQ-026 Reset SHALL NOT affect combinational outputs; nxtLoc, co, cntReach stay valid during reset.
REQ-027 Register contents after power-up and before first reset edge are undefined; bench SHALL apply reset first.

Verification
REQ-028 currLoc = 8'h35, dir = 01 -> nxtLoc = 8'h45, cntReach = 0, co = 0.
REQ-029 currLoc = 8'h35, dir = 00 -> nxtLoc = 8'h34, cntReach = 0, co = 1; dir = 11 -> nxtLoc = 8'h36, cntReach = 0.
REQ-030 currLoc = 8'hF7, dir = 01 -> nxtLoc = 8'h07, cntReach = 1, co = 1; currLoc = 8'h70, dir = 00 -> nxtLoc = 8'h7F, cntReach = 1, co = 0.
REQ-031 currLoc = 8'h0A, dir = 10 -> nxtLoc = 8'hFA, cntReach = 1; currLoc = 8'hAF, dir = 11 -> nxtLoc = 8'hA0, cntReach = 1.
REQ-032 rst = 0 one edge -> locQ = 00; then rst = 1, rgLd = 1, currLoc = 8'h5C, edge -> locQ = 8'h5C; rgLd = 0, currLoc = 8'h12, edge -> locQ stays 8'h5C.
REQ-033 locQ = 8'h5C, rgLd = 1, rst = 0 mid-cycle -> locQ unchanged until next edge, then 8'h00.
